// File: rtl/display_scan_controller.sv
// Four-digit 7-segment scan controller.
// Cycles through the digits with a SHOW slot followed by a dark BLANK gap, and
// double-buffers new display values so each frame shows one coherent set of digits.
module display_scan_controller #(
    parameter int unsigned DIV_CYCLES   = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  digit_code,
    output logic [3:0]  digit_en_n,
    output logic        frame_start,
    output logic        pending
);

    localparam int unsigned MaxCycles = (DIV_CYCLES > BLANK_CYCLES) ? DIV_CYCLES : BLANK_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] ShowLast  = CntW'(DIV_CYCLES - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

    typedef enum logic [0:0] {StShow, StBlank} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     active_data_q, active_data_d;
    logic [3:0]      active_blank_q, active_blank_d;
    logic [15:0]     shadow_data_q, shadow_data_d;
    logic [3:0]      shadow_blank_q, shadow_blank_d;
    logic            pending_q, pending_d;
    logic [3:0]      digit_code_q, digit_code_d;
    logic [3:0]      digit_en_n_q, digit_en_n_d;
    logic            frame_start_q, frame_start_d;
    logic            frame_edge;

    // Next-state: slot sequencing, shadow capture, frame-boundary transfer and output decode.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        active_data_d  = active_data_q;
        active_blank_d = active_blank_q;
        shadow_data_d  = shadow_data_q;
        shadow_blank_d = shadow_blank_q;
        pending_d      = pending_q;
        frame_edge     = 1'b0;

        unique case (state_q)
            StShow: begin
                if (cnt_q == ShowLast) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    state_d    = StShow;
                    cnt_d      = '0;
                    idx_d      = idx_q + 2'd1;
                    frame_edge = (idx_q == 2'd3);
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StBlank;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            shadow_data_d  = data_in;
            shadow_blank_d = blank_in;
            pending_d      = 1'b1;
        end

        // A load coinciding with the boundary bypasses the shadow so it is never a frame late.
        if (frame_edge) begin
            if (load) begin
                active_data_d  = data_in;
                active_blank_d = blank_in;
            end else if (pending_q) begin
                active_data_d  = shadow_data_q;
                active_blank_d = shadow_blank_q;
            end
            pending_d = 1'b0;
        end

        frame_start_d = frame_edge;
        if (state_d == StShow) begin
            digit_code_d = active_data_d[{idx_d, 2'b00} +: 4];
            digit_en_n_d = active_blank_d[idx_d] ? 4'hF : ~(4'b0001 << idx_d);
        end else begin
            digit_code_d = digit_code_q;
            digit_en_n_d = 4'hF;
        end
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StBlank;
            cnt_q          <= '0;
            idx_q          <= 2'd3;
            active_data_q  <= 16'h0000;
            active_blank_q <= 4'hF;
            shadow_data_q  <= 16'h0000;
            shadow_blank_q <= 4'h0;
            pending_q      <= 1'b0;
            digit_code_q   <= 4'h0;
            digit_en_n_q   <= 4'hF;
            frame_start_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            active_data_q  <= active_data_d;
            active_blank_q <= active_blank_d;
            shadow_data_q  <= shadow_data_d;
            shadow_blank_q <= shadow_blank_d;
            pending_q      <= pending_d;
            digit_code_q   <= digit_code_d;
            digit_en_n_q   <= digit_en_n_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign digit_code  = digit_code_q;
    assign digit_en_n  = digit_en_n_q;
    assign frame_start = frame_start_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with DIV=4, BLANK=2 (24-cycle frames).
// Expected frame contents are queued as stimulus is driven and popped per frame.
module tb_display_scan_controller;

    localparam int unsigned Div   = 4;
    localparam int unsigned Blank = 2;
    localparam int          Slot  = Div + Blank;
    localparam int          Frame = 4 * Slot;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  blank_in;
    logic [3:0]  digit_code;
    logic [3:0]  digit_en_n;
    logic        frame_start;
    logic        pending;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  blank;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    logic   exp_pend = 1'b0;

    display_scan_controller #(
        .DIV_CYCLES  (Div),
        .BLANK_CYCLES(Blank)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (data_in),
        .blank_in   (blank_in),
        .digit_code (digit_code),
        .digit_en_n (digit_en_n),
        .frame_start(frame_start),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] d, input logic [3:0] b);
        frame_t f;
        f.data  = d;
        f.blank = b;
        exp_q.push_back(f);
    endtask

    // Called at the frame_start cycle; checks one full frame and ends at the next frame_start.
    task automatic check_frame(input int pa, input logic [15:0] da, input logic [3:0] ba,
                               input int pb, input logic [15:0] db, input logic [3:0] bb);
        frame_t     f;
        int         slot;
        int         w;
        logic [3:0] en_exp;
        logic [3:0] code_exp;
        chk("sb_nonempty", 16'(exp_q.size() != 0), 16'd1);
        if (exp_q.size() != 0) f = exp_q.pop_front();
        else f = '{data: 16'h0, blank: 4'hF};
        for (int p = 0; p < Frame; p++) begin
            slot     = p / Slot;
            w        = p % Slot;
            en_exp   = (w < Div && !f.blank[slot]) ? ~(4'b0001 << slot) : 4'hF;
            code_exp = f.data[slot*4 +: 4];
            chk("digit_en_n", 16'(digit_en_n), 16'(en_exp));
            chk("digit_code", 16'(digit_code), 16'(code_exp));
            chk("frame_start", 16'(frame_start), 16'(p == 0));
            chk("pending", 16'(pending), 16'(exp_pend));
            if (p == pa) begin
                load = 1'b1; data_in = da; blank_in = ba;
            end else if (p == pb) begin
                load = 1'b1; data_in = db; blank_in = bb;
            end else begin
                load = 1'b0;
            end
            tick();
            if ((p == pa || p == pb) && p < Frame - 1) exp_pend = 1'b1;
        end
        load     = 1'b0;
        exp_pend = 1'b0;
        chk("frame_period", 16'(frame_start), 16'd1);
        chk("pending_boundary", 16'(pending), 16'd0);
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        data_in  = 16'h0;
        blank_in = 4'h0;

        // Reset period, with a load that reset must override.
        for (int i = 0; i < 3; i++) begin
            load = (i == 1); data_in = 16'hFFFF;
            tick();
            chk("rst_en", 16'(digit_en_n), 16'hF);
            chk("rst_fs", 16'(frame_start), 16'd0);
            chk("rst_pend", 16'(pending), 16'd0);
            chk("rst_code", 16'(digit_code), 16'h0);
        end
        load  = 1'b0;
        reset = 1'b0;
        tick();
        chk("rel1_fs", 16'(frame_start), 16'd0);
        chk("rel1_en", 16'(digit_en_n), 16'hF);
        tick();
        chk("rel2_fs", 16'(frame_start), 16'd1);

        // Frame 1: dark after reset.
        push_exp(16'h0000, 4'hF);
        check_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        // Frame 2: still dark, load 4321 mid-frame.
        push_exp(16'h0000, 4'hF);
        check_frame(5, 16'h4321, 4'h0, -1, 16'h0, 4'h0);
        // Frame 3: shows 4321; two loads, last wins.
        push_exp(16'h4321, 4'h0);
        check_frame(3, 16'h1111, 4'h0, 10, 16'h9876, 4'h0);
        // Frame 4: shows 9876; load on the boundary cycle.
        push_exp(16'h9876, 4'h0);
        check_frame(Frame - 1, 16'h5555, 4'h0, -1, 16'h0, 4'h0);
        // Frame 5: shows 5555 immediately; load blanked pattern with hex codes A-D.
        push_exp(16'h5555, 4'h0);
        check_frame(8, 16'hABCD, 4'b0101, -1, 16'h0, 4'h0);
        // Frame 6: digits 0 and 2 dark; load 2468.
        push_exp(16'hABCD, 4'b0101);
        check_frame(2, 16'h2468, 4'h0, -1, 16'h0, 4'h0);

        // Frame 7: load to set pending, then reset during digit-2 SHOW.
        for (int p = 0; p < 13; p++) begin
            load = (p == 1);
            if (p == 1) begin
                data_in = 16'h1357; blank_in = 4'h0;
            end
            tick();
        end
        load = 1'b0;
        chk("d2_en", 16'(digit_en_n), 16'hB);
        chk("d2_code", 16'(digit_code), 16'h4);
        chk("d2_pend", 16'(pending), 16'd1);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("mid_rst_en", 16'(digit_en_n), 16'hF);
            chk("mid_rst_pend", 16'(pending), 16'd0);
            chk("mid_rst_fs", 16'(frame_start), 16'd0);
            chk("mid_rst_code", 16'(digit_code), 16'h0);
        end
        reset = 1'b0;
        tick();
        chk("rel_b1_fs", 16'(frame_start), 16'd0);
        chk("rel_b1_en", 16'(digit_en_n), 16'hF);
        tick();
        chk("rel_b2_fs", 16'(frame_start), 16'd1);
        exp_pend = 1'b0;
        push_exp(16'h0000, 4'hF);
        check_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        push_exp(16'h0000, 4'hF);
        check_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
